// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg
//   Shared definitions for the data-memory arbitration slice:
//   default bus widths, arbiter FSM state encoding and the
//   port-select constants used by the memory-side mux.
package rv_mem_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic {
      ARB_IDLE      = 1'b0,
      ARB_FORCE_AUX = 1'b1
   } arb_state_t;

   typedef enum logic {
      SEL_CORE = 1'b0,
      SEL_AUX  = 1'b1
   } port_sel_t;

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single data_mem port between the core load/store unit
//   (default priority) and an auxiliary master (boot loader / debug / DMA).
//   A starvation counter forces a one-cycle aux grant once aux has been
//   blocked by the core for STARVE_LIMIT consecutive cycles; the core is
//   stalled for that cycle.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ARB_IDLE  | core has priority, aux granted only when core is idle
//   FORCE_AUX | aux owns the port for exactly one cycle, core stalled
//
// Ports
//   clk, rst                    clock, async active-high reset
//   core_req/we/addr/wdata      core request (combinational grant)
//   core_rdata                  load data, pass-through of mem_rdata
//   core_stall                  core must hold its request this cycle
//   aux_valid/we/addr/wdata     aux request, held until aux_ready
//   aux_ready                   aux request accepted this cycle
//   aux_rvalid, aux_rdata       registered aux read response
//   mem_write/read/addr/wdata   to data_mem
//   mem_rdata                   from data_mem (combinational read)
module dmem_arbiter
   import rv_mem_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_stall,
   input  logic              aux_valid,
   input  logic              aux_we,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic [DATA_W-1:0] aux_wdata,
   output logic              aux_ready,
   output logic              aux_rvalid,
   output logic [DATA_W-1:0] aux_rdata,
   output logic              mem_write,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

   arb_state_t       state;
   logic [CNT_W-1:0] starve_cnt;
   port_sel_t        sel;
   logic             granted_req;
   logic             granted_we;
   logic             aux_xfer;

   // Port selection is combinational so the core gets same-cycle access.
   always_comb begin
      sel = SEL_CORE;
      if (state == ARB_FORCE_AUX)
         sel = SEL_AUX;
      else if (!core_req && aux_valid)
         sel = SEL_AUX;
   end

   always_comb begin
      granted_req = core_req;
      granted_we  = core_we;
      mem_addr    = core_addr;
      mem_wdata   = core_wdata;
      if (sel == SEL_AUX) begin
         granted_req = aux_valid;
         granted_we  = aux_we;
         mem_addr    = aux_addr;
         mem_wdata   = aux_wdata;
      end
   end

   // Strobes are gated by rst so nothing reaches data_mem during reset.
   assign mem_write  = !rst &&  granted_we && granted_req;
   assign mem_read   = !rst && !granted_we && granted_req;
   assign aux_ready  = !rst && (sel == SEL_AUX) && aux_valid;
   assign core_stall = !rst && (state == ARB_FORCE_AUX) && core_req;
   assign core_rdata = mem_rdata;
   assign aux_xfer   = aux_valid && aux_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ARB_IDLE;
         starve_cnt <= '0;
         aux_rvalid <= 1'b0;
         aux_rdata  <= '0;
      end else begin
         aux_rvalid <= aux_xfer && !aux_we;
         if (aux_xfer && !aux_we)
            aux_rdata <= mem_rdata;

         case (state)
            ARB_IDLE: begin
               if (aux_valid && core_req) begin
                  if (starve_cnt != LIMIT)
                     starve_cnt <= starve_cnt + 1'b1;
                  if (starve_cnt == LIMIT_M1)
                     state <= ARB_FORCE_AUX;
               end else begin
                  // aux idle or granted this cycle
                  starve_cnt <= '0;
               end
            end
            ARB_FORCE_AUX: begin
               starve_cnt <= '0;
               state      <= ARB_IDLE;
            end
            default: begin
               starve_cnt <= '0;
               state      <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

   logic        clk;
   logic        rst;
   logic        core_req;
   logic        core_we;
   logic [31:0] core_addr;
   logic [31:0] core_wdata;
   logic [31:0] core_rdata;
   logic        core_stall;
   logic        aux_valid;
   logic        aux_we;
   logic [31:0] aux_addr;
   logic [31:0] aux_wdata;
   logic        aux_ready;
   logic        aux_rvalid;
   logic [31:0] aux_rdata;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] tmem [0:63];

   dmem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .CNT_W(4)
   ) dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
      .aux_valid(aux_valid), .aux_we(aux_we), .aux_addr(aux_addr),
      .aux_wdata(aux_wdata), .aux_ready(aux_ready), .aux_rvalid(aux_rvalid),
      .aux_rdata(aux_rdata),
      .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // data_mem model: combinational read, write at posedge
   always @(posedge clk) if (mem_write) tmem[mem_addr[7:2]] <= mem_wdata;
   assign mem_rdata = mem_read ? tmem[mem_addr[7:2]] : 32'h0;

   task automatic idle_inputs();
      core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
      aux_valid = 0; aux_we = 0; aux_addr = 0; aux_wdata = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      core_req = 1; core_we = 1; core_addr = 32'h4; core_wdata = 32'h1;
      aux_valid = 1; aux_we = 1; aux_addr = 32'h8; aux_wdata = 32'h2;
      @(negedge clk); #1;
      n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL rst_mem_write got=%b want=0", mem_write); end
      n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL rst_mem_read got=%b want=0", mem_read); end
      n_checks++; if (aux_ready !== 1'b0) begin n_fail++; $display("FAIL rst_aux_ready got=%b want=0", aux_ready); end
      n_checks++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL rst_core_stall got=%b want=0", core_stall); end
      n_checks++; if (aux_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_aux_rvalid got=%b want=0", aux_rvalid); end
      n_checks++; if (aux_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_aux_rdata got=%h want=0", aux_rdata); end
      @(negedge clk);
      rst = 0;
      idle_inputs();
      core_addr = 32'h44; core_wdata = 32'h55;
      #1;
      n_checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin n_fail++; $display("FAIL idle_strobes got=%b%b want=00", mem_read, mem_write); end
      n_checks++; if (mem_addr !== 32'h44) begin n_fail++; $display("FAIL idle_mem_addr got=%h want=44", mem_addr); end
      n_checks++; if (mem_wdata !== 32'h55) begin n_fail++; $display("FAIL idle_mem_wdata got=%h want=55", mem_wdata); end
   endtask

   task automatic test_core_only();
      @(negedge clk);
      idle_inputs();
      core_req = 1; core_we = 1; core_addr = 32'h04; core_wdata = 32'hDEADBEEF;
      #1;
      n_checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin n_fail++; $display("FAIL core_st_strobes got=w%b r%b want=w1 r0", mem_write, mem_read); end
      n_checks++; if (mem_addr !== 32'h04 || mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL core_st_bus got=%h/%h want=4/deadbeef", mem_addr, mem_wdata); end
      n_checks++; if (core_stall !== 1'b0 || aux_ready !== 1'b0) begin n_fail++; $display("FAIL core_st_flags got=stall%b rdy%b want=0 0", core_stall, aux_ready); end
      @(negedge clk);
      core_we = 0; core_wdata = 0;
      #1;
      n_checks++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL core_ld_read got=%b want=1", mem_read); end
      n_checks++; if (core_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL core_ld_data got=%h want=deadbeef", core_rdata); end
      n_checks++; if (core_stall !== 1'b0 || aux_ready !== 1'b0) begin n_fail++; $display("FAIL core_ld_flags got=stall%b rdy%b want=0 0", core_stall, aux_ready); end
   endtask

   task automatic test_aux_only();
      @(negedge clk);
      idle_inputs();
      aux_valid = 1; aux_we = 1; aux_addr = 32'h10; aux_wdata = 32'hCAFEBABE;
      #1;
      n_checks++; if (aux_ready !== 1'b1 || mem_write !== 1'b1) begin n_fail++; $display("FAIL aux_wr0 got=rdy%b w%b want=1 1", aux_ready, mem_write); end
      n_checks++; if (mem_addr !== 32'h10 || mem_wdata !== 32'hCAFEBABE) begin n_fail++; $display("FAIL aux_wr0_bus got=%h/%h want=10/cafebabe", mem_addr, mem_wdata); end
      @(negedge clk);
      aux_addr = 32'h20; aux_wdata = 32'h12345678;
      #1;
      n_checks++; if (aux_ready !== 1'b1 || aux_rvalid !== 1'b0) begin n_fail++; $display("FAIL aux_wr1 got=rdy%b rv%b want=1 0", aux_ready, aux_rvalid); end
      @(negedge clk);
      aux_we = 0; aux_addr = 32'h10; aux_wdata = 0;
      #1;
      n_checks++; if (aux_ready !== 1'b1 || mem_read !== 1'b1 || aux_rvalid !== 1'b0) begin n_fail++; $display("FAIL aux_rd got=rdy%b r%b rv%b want=1 1 0", aux_ready, mem_read, aux_rvalid); end
      @(negedge clk);
      aux_valid = 0;
      #1;
      n_checks++; if (aux_rvalid !== 1'b1 || aux_rdata !== 32'hCAFEBABE) begin n_fail++; $display("FAIL aux_rd_resp got=rv%b %h want=1 cafebabe", aux_rvalid, aux_rdata); end
      @(negedge clk); #1;
      n_checks++; if (aux_rvalid !== 1'b0 || aux_rdata !== 32'hCAFEBABE) begin n_fail++; $display("FAIL aux_rd_hold got=rv%b %h want=0 cafebabe", aux_rvalid, aux_rdata); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      idle_inputs();
      aux_valid = 1; aux_addr = 32'h10;
      #1;
      n_checks++; if (aux_ready !== 1'b1 || aux_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_c0 got=rdy%b rv%b want=1 0", aux_ready, aux_rvalid); end
      @(negedge clk);
      aux_addr = 32'h20;
      #1;
      n_checks++; if (aux_ready !== 1'b1 || aux_rvalid !== 1'b1 || aux_rdata !== 32'hCAFEBABE) begin n_fail++; $display("FAIL b2b_c1 got=rdy%b rv%b %h want=1 1 cafebabe", aux_ready, aux_rvalid, aux_rdata); end
      @(negedge clk);
      aux_valid = 0;
      #1;
      n_checks++; if (aux_rvalid !== 1'b1 || aux_rdata !== 32'h12345678) begin n_fail++; $display("FAIL b2b_c2 got=rv%b %h want=1 12345678", aux_rvalid, aux_rdata); end
      @(negedge clk); #1;
      n_checks++; if (aux_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_c3 got=rv%b want=0", aux_rvalid); end
   endtask

   task automatic test_contention();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         idle_inputs();
         core_req = 1; core_addr = 32'h04;
         aux_valid = 1; aux_addr = 32'h20;
         #1;
         n_checks++; if (aux_ready !== 1'b0 || core_stall !== 1'b0) begin n_fail++; $display("FAIL cont_core_c%0d got=rdy%b stall%b want=0 0", c, aux_ready, core_stall); end
         n_checks++; if (mem_addr !== 32'h04 || core_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cont_core_bus_c%0d got=%h/%h want=4/deadbeef", c, mem_addr, core_rdata); end
      end
      @(negedge clk); #1;
      n_checks++; if (aux_ready !== 1'b1 || core_stall !== 1'b1) begin n_fail++; $display("FAIL cont_force got=rdy%b stall%b want=1 1", aux_ready, core_stall); end
      n_checks++; if (mem_addr !== 32'h20 || mem_read !== 1'b1) begin n_fail++; $display("FAIL cont_force_bus got=%h r%b want=20 1", mem_addr, mem_read); end
      @(negedge clk);
      aux_valid = 0;
      #1;
      n_checks++; if (core_stall !== 1'b0 || mem_addr !== 32'h04) begin n_fail++; $display("FAIL cont_back got=stall%b %h want=0 4", core_stall, mem_addr); end
      n_checks++; if (aux_rvalid !== 1'b1 || aux_rdata !== 32'h12345678) begin n_fail++; $display("FAIL cont_rvalid got=rv%b %h want=1 12345678", aux_rvalid, aux_rdata); end
   endtask

   task automatic test_withdraw();
      int bad;
      bad = 0;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         idle_inputs();
         core_req = 1; core_addr = 32'h04;
         aux_valid = (c != 2); aux_addr = 32'h10;
         #1;
         if (core_stall !== 1'b0 || aux_ready !== 1'b0) bad++;
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL wd_no_force got=%0d stalled cycles want=0", bad); end
      // counter restarted at cycle 3, so the forced grant lands at cycle 7
      @(negedge clk); #1;
      n_checks++; if (core_stall !== 1'b1 || aux_ready !== 1'b1) begin n_fail++; $display("FAIL wd_force got=stall%b rdy%b want=1 1", core_stall, aux_ready); end
      @(negedge clk);
      idle_inputs();
      #1;
      n_checks++; if (aux_rvalid !== 1'b1 || aux_rdata !== 32'hCAFEBABE) begin n_fail++; $display("FAIL wd_rvalid got=rv%b %h want=1 cafebabe", aux_rvalid, aux_rdata); end
   endtask

   task automatic test_same_addr();
      @(negedge clk);
      idle_inputs();
      core_req = 1; core_we = 1; core_addr = 32'h08; core_wdata = 32'h11111111;
      aux_valid = 1; aux_we = 1; aux_addr = 32'h08; aux_wdata = 32'h22222222;
      #1;
      n_checks++; if (aux_ready !== 1'b0 || mem_wdata !== 32'h11111111) begin n_fail++; $display("FAIL same_core_win got=rdy%b %h want=0 11111111", aux_ready, mem_wdata); end
      @(negedge clk);
      core_req = 0; core_we = 0;
      #1;
      n_checks++; if (tmem[2] !== 32'h11111111) begin n_fail++; $display("FAIL same_mem_core got=%h want=11111111", tmem[2]); end
      n_checks++; if (aux_ready !== 1'b1 || mem_wdata !== 32'h22222222) begin n_fail++; $display("FAIL same_aux_later got=rdy%b %h want=1 22222222", aux_ready, mem_wdata); end
      @(negedge clk);
      idle_inputs();
      #1;
      n_checks++; if (tmem[2] !== 32'h22222222) begin n_fail++; $display("FAIL same_mem_aux got=%h want=22222222", tmem[2]); end
   endtask

   task automatic test_async_reset();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         idle_inputs();
         core_req = 1; core_addr = 32'h04;
         aux_valid = 1; aux_we = 1; aux_addr = 32'h08; aux_wdata = 32'h99;
      end
      #1;
      n_checks++; if (core_stall !== 1'b1 || mem_write !== 1'b1) begin n_fail++; $display("FAIL ar_in_force got=stall%b w%b want=1 1", core_stall, mem_write); end
      #2 rst = 1;
      #1;
      n_checks++; if (core_stall !== 1'b0 || aux_ready !== 1'b0) begin n_fail++; $display("FAIL ar_imm_flags got=stall%b rdy%b want=0 0", core_stall, aux_ready); end
      n_checks++; if (mem_write !== 1'b0 || aux_rvalid !== 1'b0) begin n_fail++; $display("FAIL ar_imm_mem got=w%b rv%b want=0 0", mem_write, aux_rvalid); end
      @(negedge clk);
      n_checks++; if (tmem[2] !== 32'h22222222) begin n_fail++; $display("FAIL ar_no_write got=%h want=22222222", tmem[2]); end
      rst = 0;
      #1;
      n_checks++; if (core_stall !== 1'b0 || aux_ready !== 1'b0 || mem_addr !== 32'h04) begin n_fail++; $display("FAIL ar_idle got=stall%b rdy%b %h want=0 0 4", core_stall, aux_ready, mem_addr); end
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      test_reset();
      test_core_only();
      test_aux_only();
      test_back_to_back();
      test_contention();
      test_withdraw();
      test_same_addr();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout reached at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
